instr_encoder: RTL and testbench

//  Program-loader front end: accepts symbolic instruction requests over a valid/ready handshake.

---
 rtl/instr_enc_pkg.sv | 50 +++++
 rtl/instr_encoder_if.sv | 28 ++
 rtl/instr_enc_fifo.sv | 51 +++++
 rtl/instr_encoder.sv | 167 ++++++++++++++++
 tb/tb_instr_encoder.sv | 384 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_enc_pkg.sv
// Shared definitions for the instruction encoder (program-loader front end).
// Holds the decode-class op codes, RV32I opcode/funct3 constants, the
// queued request payload and the loader FSM state type.
package instr_enc_pkg;

   // Decode class {funct3[1:0], opcode[5:4]} as seen by the core's decode stage
   localparam logic [3:0] OP_ADD  = 4'b0011;
   localparam logic [3:0] OP_SLT  = 4'b1011;
   localparam logic [3:0] OP_SLL  = 4'b0111;
   localparam logic [3:0] OP_ADDI = 4'b0001;
   localparam logic [3:0] OP_SLTI = 4'b1001;
   localparam logic [3:0] OP_SLLI = 4'b0101;
   localparam logic [3:0] OP_LW   = 4'b1000;
   localparam logic [3:0] OP_SW   = 4'b1010;
   localparam logic [3:0] OP_BEQ  = 4'b0010;

   localparam logic [6:0] OPC_REG    = 7'b0110011;
   localparam logic [6:0] OPC_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_WORD = 3'b010;
   localparam logic [2:0] F3_BEQ  = 3'b000;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ENC,
      ST_WRITE,
      ST_DONE
   } encState_t;

   typedef struct packed {
      logic [3:0]  op;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
      logic        last;
   } request_t;

   typedef struct packed {
      logic        legal;
      logic [31:0] word;
   } encoded_t;

endpackage

// File: rtl/instr_encoder_if.sv
// Request handshake and imem write port of the instruction encoder.
// slave = encoder side, master = host/memory side.
interface instr_encoder_if #(
   parameter int ADDR_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic [3:0]        req_op;
   logic [4:0]        req_rd;
   logic [4:0]        req_rs1;
   logic [4:0]        req_rs2;
   logic [31:0]       req_imm;
   logic              req_last;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_data;
   logic              imem_ack;

   modport master (
      output req_valid, req_op, req_rd, req_rs1, req_rs2, req_imm, req_last, imem_ack,
      input  req_ready, imem_we, imem_addr, imem_data
   );

   modport slave (
      input  req_valid, req_op, req_rd, req_rs1, req_rs2, req_imm, req_last, imem_ack,
      output req_ready, imem_we, imem_addr, imem_data
   );
endinterface

// File: rtl/instr_enc_fifo.sv
// Synchronous request FIFO for the instruction encoder.
// Head entry is visible combinationally on o_data while not empty.
module instr_enc_fifo
   import instr_enc_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     i_push,
   input  request_t i_data,
   input  logic     i_pop,
   output request_t o_data,
   output logic     o_full,
   output logic     o_empty
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] PTR_ONE = 1;

   request_t       r_mem [DEPTH];
   logic [PTR_W:0] r_wrPtr;
   logic [PTR_W:0] r_rdPtr;

   // Payload storage; contents are don't-care until written so no reset is needed
   always_ff @(posedge clk) begin
      if (i_push) begin
         r_mem[r_wrPtr[PTR_W-1:0]] <= i_data;
      end
   end

   // Read/write pointers carry one extra wrap bit to tell full from empty
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
      end else begin
         if (i_push) begin
            r_wrPtr <= r_wrPtr + PTR_ONE;
         end
         if (i_pop) begin
            r_rdPtr <= r_rdPtr + PTR_ONE;
         end
      end
   end

   assign o_empty = (r_wrPtr == r_rdPtr);
   assign o_full  = (r_wrPtr[PTR_W] != r_rdPtr[PTR_W]) &&
                    (r_wrPtr[PTR_W-1:0] == r_rdPtr[PTR_W-1:0]);
   assign o_data  = r_mem[r_rdPtr[PTR_W-1:0]];

endmodule

// File: rtl/instr_encoder.sv
// Program-loader front end: queues symbolic instruction requests, encodes
// each into an RV32I-subset word and writes it to imem at a self-incrementing
// address. Optional macro INSTR_ENC_IMM_CHECK_EN enables immediate range
// checking; without it immediates are truncated to their field width.
module instr_encoder
   import instr_enc_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_start,
   input  logic [ADDR_W-1:0] i_base_addr,
   instr_encoder_if.slave    bus,
   output logic              o_err,
   output logic              o_done,
   output logic [15:0]       o_count
);
   localparam logic [ADDR_W-1:0] WORD_BYTES = 4;

   encState_t         r_state;
   logic [ADDR_W-1:0] r_wrAddr;
   logic [15:0]       r_count;
   logic [31:0]       r_word;
   logic              r_legal;
   logic              r_last;
   logic              r_we;
   logic              r_err;
   logic              r_done;

   request_t w_reqIn;
   request_t w_head;
   encoded_t w_enc;
   logic     w_full;
   logic     w_empty;
   logic     w_push;
   logic     w_pop;

   // Builds the instruction word for one request and flags unknown ops or
   // out-of-range immediates so the FSM can drop them.
   function automatic encoded_t encodeReq(input request_t req);
      encoded_t         res;
      logic             immOkI;
      logic             immOkSh;
      logic             immOkB;
`ifdef INSTR_ENC_IMM_CHECK_EN
      logic signed [31:0] imm;
      imm     = req.imm;
      immOkI  = (imm >= -32'sd2048) && (imm <= 32'sd2047);
      immOkSh = (imm >= 32'sd0) && (imm <= 32'sd31);
      immOkB  = (imm >= -32'sd4096) && (imm <= 32'sd4094) && !req.imm[0];
`else
      immOkI  = 1'b1;
      immOkSh = 1'b1;
      immOkB  = 1'b1;
`endif
      res = '0;
      case (req.op)
         OP_ADD:  res = '{1'b1, {7'b0, req.rs2, req.rs1, F3_ADD, req.rd, OPC_REG}};
         OP_SLT:  res = '{1'b1, {7'b0, req.rs2, req.rs1, F3_SLT, req.rd, OPC_REG}};
         OP_SLL:  res = '{1'b1, {7'b0, req.rs2, req.rs1, F3_SLL, req.rd, OPC_REG}};
         OP_ADDI: res = '{immOkI, {req.imm[11:0], req.rs1, F3_ADD, req.rd, OPC_IMM}};
         OP_SLTI: res = '{immOkI, {req.imm[11:0], req.rs1, F3_SLT, req.rd, OPC_IMM}};
         OP_SLLI: res = '{immOkSh, {7'b0, req.imm[4:0], req.rs1, F3_SLL, req.rd, OPC_IMM}};
         OP_LW:   res = '{immOkI, {req.imm[11:0], req.rs1, F3_WORD, req.rd, OPC_LOAD}};
         OP_SW:   res = '{immOkI, {req.imm[11:5], req.rs2, req.rs1, F3_WORD,
                                   req.imm[4:0], OPC_STORE}};
         OP_BEQ:  res = '{immOkB, {req.imm[12], req.imm[10:5], req.rs2, req.rs1, F3_BEQ,
                                   req.imm[4:1], req.imm[11], OPC_BRANCH}};
         default: res = '0;
      endcase
      return res;
   endfunction

   assign w_reqIn = '{bus.req_op, bus.req_rd, bus.req_rs1, bus.req_rs2,
                      bus.req_imm, bus.req_last};
   assign w_pop   = (r_state == ST_IDLE) && !w_empty;
   assign w_push  = bus.req_valid && bus.req_ready;
   assign w_enc   = encodeReq(w_head);

   instr_enc_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_data  (w_reqIn),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Loader FSM: pop and encode, then either drop with err or hold the write
   // until imem acknowledges; done follows the acked write of the last word.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_wrAddr <= '0;
         r_count  <= '0;
         r_word   <= '0;
         r_legal  <= 1'b0;
         r_last   <= 1'b0;
         r_we     <= 1'b0;
         r_err    <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_err  <= 1'b0;
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_empty) begin
                  if (i_start) begin
                     r_wrAddr <= i_base_addr;
                     r_count  <= '0;
                  end
               end else begin
                  r_word  <= w_enc.word;
                  r_legal <= w_enc.legal;
                  r_last  <= w_head.last;
                  r_state <= ST_ENC;
               end
            end
            ST_ENC: begin
               if (r_legal) begin
                  r_we    <= 1'b1;
                  r_state <= ST_WRITE;
               end else begin
                  r_err   <= 1'b1;
                  r_state <= ST_IDLE;
               end
            end
            ST_WRITE: begin
               if (bus.imem_ack) begin
                  r_we     <= 1'b0;
                  r_wrAddr <= r_wrAddr + WORD_BYTES;
                  if (r_count != 16'hFFFF) begin
                     r_count <= r_count + 16'd1;
                  end
                  if (r_last) begin
                     r_done  <= 1'b1;
                     r_state <= ST_DONE;
                  end else begin
                     r_state <= ST_IDLE;
                  end
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready = !w_full || w_pop;
   assign bus.imem_we   = r_we;
   assign bus.imem_addr = r_wrAddr;
   assign bus.imem_data = r_word;
   assign o_err         = r_err;
   assign o_done        = r_done;
   assign o_count       = r_count;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder. A request-level model turns every
// accepted request into an expected write (or drop) in arrival order; one
// negedge process checks imem, err, done and count against it every cycle.
module tb_instr_encoder;

   localparam logic [3:0] OP_ADD  = 4'b0011;
   localparam logic [3:0] OP_SLT  = 4'b1011;
   localparam logic [3:0] OP_SLL  = 4'b0111;
   localparam logic [3:0] OP_ADDI = 4'b0001;
   localparam logic [3:0] OP_SLTI = 4'b1001;
   localparam logic [3:0] OP_SLLI = 4'b0101;
   localparam logic [3:0] OP_LW   = 4'b1000;
   localparam logic [3:0] OP_SW   = 4'b1010;
   localparam logic [3:0] OP_BEQ  = 4'b0010;
   localparam logic [3:0] OP_BAD  = 4'b1111;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] baseAddr;
   logic        err;
   logic        done;
   logic [15:0] count;

   instr_encoder_if #(.ADDR_W(32)) bus ();

   instr_encoder #(
      .DEPTH  (4),
      .ADDR_W (32)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .i_start     (start),
      .i_base_addr (baseAddr),
      .bus         (bus.slave),
      .o_err       (err),
      .o_done      (done),
      .o_count     (count)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          illegal;
      logic [31:0] addr;
      logic [31:0] data;
      bit          last;
   } expEntry_t;

   expEntry_t   expQ[$];
   logic [31:0] wrAddrLog[$];
   logic [31:0] wrDataLog[$];
   int          checks    = 0;
   int          failures  = 0;
   int          errSeen   = 0;
   int          doneSeen  = 0;
   logic [31:0] modelAddr = 0;
   int          modelCount = 0;
   bit          doneDue   = 0;
   bit          rstPrev   = 0;
   bit          ackEn     = 1;
   int          ackHold   = 0;

   // Compare one value and report a mismatch
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Record a check that could not be made (timeout or missing event)
   task automatic failNote(input string name);
      checks++;
      failures++;
      $display("[TB] FAIL %s: event did not occur within its bound", name);
   endtask

   // Check an entry of the write log against a hand-computed value
   task automatic checkLog(input string name, input int idx, input bit isAddr,
                           input logic [31:0] expected);
      if (idx >= wrDataLog.size()) begin
         failNote(name);
      end else begin
         checkOutput(name, isAddr ? wrAddrLog[idx] : wrDataLog[idx], expected);
      end
   endtask

   // Reference encoder written from the field layouts with plain arithmetic
   function automatic logic [31:0] modelEncode(input logic [3:0] op, input int rd,
                                               input int rs1, input int rs2, input int imm,
                                               output bit legal);
      longint w, lrd, lrs1, lrs2, li;
      int     kind;
      longint opcode, f3;
      lrd = rd; lrs1 = rs1; lrs2 = rs2; li = imm;
      legal = 1;
      kind = 0; opcode = 0; f3 = 0;
      case (op)
         OP_ADD:  begin kind = 0; opcode = 51; f3 = 0; end
         OP_SLT:  begin kind = 0; opcode = 51; f3 = 2; end
         OP_SLL:  begin kind = 0; opcode = 51; f3 = 1; end
         OP_ADDI: begin kind = 1; opcode = 19; f3 = 0; end
         OP_SLTI: begin kind = 1; opcode = 19; f3 = 2; end
         OP_SLLI: begin kind = 2; opcode = 19; f3 = 1; end
         OP_LW:   begin kind = 1; opcode = 3;  f3 = 2; end
         OP_SW:   begin kind = 3; opcode = 35; f3 = 2; end
         OP_BEQ:  begin kind = 4; opcode = 99; f3 = 0; end
         default: begin legal = 0; return 32'h0; end
      endcase
`ifdef INSTR_ENC_IMM_CHECK_EN
      if (kind == 1 || kind == 3) legal = (imm >= -2048) && (imm <= 2047);
      if (kind == 2) legal = (imm >= 0) && (imm <= 31);
      if (kind == 4) legal = (imm >= -4096) && (imm <= 4094) && (imm % 2 == 0);
`endif
      w = opcode + (f3 << 12) + (lrs1 << 15);
      case (kind)
         0: w += (lrd << 7) + (lrs2 << 20);
         1: w += (lrd << 7) + ((li & 4095) << 20);
         2: w += (lrd << 7) + ((li & 31) << 20);
         3: w += ((li & 31) << 7) + (lrs2 << 20) + (((li >> 5) & 127) << 25);
         default: w += (lrs2 << 20) + (((li >> 1) & 15) << 8) + (((li >> 11) & 1) << 7)
                     + (((li >> 5) & 63) << 25) + (((li >> 12) & 1) << 31);
      endcase
      return w[31:0];
   endfunction

   // Compare process: checks the DUT against the model each cycle and feeds the model
   always @(negedge clk) begin : compareProc
      expEntry_t e;
      bit        legal;
      if (rst) begin
         if (rstPrev) begin
            checkOutput("rst_we", bus.imem_we, 0);
            checkOutput("rst_addr", bus.imem_addr, 0);
            checkOutput("rst_data", bus.imem_data, 0);
            checkOutput("rst_err", err, 0);
            checkOutput("rst_done", done, 0);
            checkOutput("rst_ready", bus.req_ready, 1);
            checkOutput("rst_count", count, 0);
         end
         expQ.delete();
         modelAddr  = 0;
         modelCount = 0;
         doneDue    = 0;
         rstPrev    = 1;
      end else begin
         rstPrev = 0;
         checkOutput("done", done, doneDue);
         if (done) doneSeen++;
         doneDue = 0;
         checkOutput("count", count, modelCount);
         if (err) begin
            errSeen++;
            if (expQ.size() == 0 || !expQ[0].illegal) failNote("err_unexpected");
            else void'(expQ.pop_front());
         end
         if (bus.imem_we) begin
            if (expQ.size() == 0 || expQ[0].illegal) begin
               failNote("we_unexpected");
            end else begin
               checkOutput("wr_addr", bus.imem_addr, expQ[0].addr);
               checkOutput("wr_data", bus.imem_data, expQ[0].data);
               if (bus.imem_ack) begin
                  wrAddrLog.push_back(bus.imem_addr);
                  wrDataLog.push_back(bus.imem_data);
                  if (modelCount < 65535) modelCount++;
                  doneDue = expQ[0].last;
                  void'(expQ.pop_front());
               end
            end
         end
         if (start) begin
            modelAddr  = baseAddr;
            modelCount = 0;
         end
         if (bus.req_valid && bus.req_ready) begin
            e.data    = modelEncode(bus.req_op, int'(bus.req_rd), int'(bus.req_rs1),
                                    int'(bus.req_rs2), int'($signed(bus.req_imm)), legal);
            e.illegal = !legal;
            e.addr    = modelAddr;
            e.last    = bus.req_last;
            expQ.push_back(e);
            if (legal) modelAddr = modelAddr + 32'd4;
         end
      end
   end

   // Memory model: acknowledges writes unless disabled or holding off
   always @(posedge clk) begin
      #1;
      if (ackHold > 0 && bus.imem_we) begin
         bus.imem_ack = 1'b0;
         ackHold--;
      end else begin
         bus.imem_ack = ackEn && bus.imem_we;
      end
   end

   // Offer one request and wait (bounded) until it is accepted
   task automatic applyStimulus(input logic [3:0] op, input int rd, input int rs1,
                                input int rs2, input int imm, input bit last);
      bit accepted = 0;
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_rd    = 5'(rd);
      bus.req_rs1   = 5'(rs1);
      bus.req_rs2   = 5'(rs2);
      bus.req_imm   = 32'(imm);
      bus.req_last  = last;
      for (int i = 0; i < 100 && !accepted; i++) begin
         @(negedge clk);
         if (bus.req_ready) accepted = 1;
      end
      if (!accepted) failNote("push_timeout");
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      start         = 1'b0;
   endtask

   // Pulse start with a new base address while the loader is idle
   task automatic doStart(input logic [31:0] base);
      start    = 1'b1;
      baseAddr = base;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Wait (bounded) until every expected event has happened
   task automatic waitIdle(input string name);
      bit idle = 0;
      for (int i = 0; i < 300 && !idle; i++) begin
         @(negedge clk);
         if (expQ.size() == 0 && !bus.imem_we) idle = 1;
      end
      if (!idle) failNote(name);
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   initial begin : watchdog
      #400000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stimulus
      int          logBase;
      int          errBase;
      int          doneBase;
      bit          legal;
      logic [31:0] w;
      bit          seenWe;

      rst = 1'b1; start = 1'b0; baseAddr = 0;
      bus.req_valid = 1'b0; bus.req_op = 0; bus.req_rd = 0; bus.req_rs1 = 0;
      bus.req_rs2 = 0; bus.req_imm = 0; bus.req_last = 0; bus.imem_ack = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      $display("[TB] pinning the reference encoder");
      checkOutput("model_addi", modelEncode(OP_ADDI, 1, 0, 0, 5, legal), 32'h00500093);
      checkOutput("model_add", modelEncode(OP_ADD, 3, 1, 2, 0, legal), 32'h002081B3);
      checkOutput("model_lw", modelEncode(OP_LW, 5, 2, 0, 8, legal), 32'h00812283);
      checkOutput("model_sw", modelEncode(OP_SW, 0, 2, 5, 12, legal), 32'h00512623);
      checkOutput("model_beq", modelEncode(OP_BEQ, 0, 1, 2, -8, legal), 32'hFE208CE3);
      w = modelEncode(OP_BAD, 1, 1, 1, 0, legal);
      checkOutput("model_bad_legal", 32'(legal), 0);

      $display("[TB] encoding of every op class");
      doStart(32'h0);
      logBase = wrDataLog.size();
      applyStimulus(OP_ADDI, 1, 0, 0, 5, 0);
      applyStimulus(OP_ADD, 3, 1, 2, 0, 0);
      applyStimulus(OP_LW, 5, 2, 0, 8, 0);
      applyStimulus(OP_SW, 0, 2, 5, 12, 0);
      applyStimulus(OP_BEQ, 0, 1, 2, -8, 0);
      applyStimulus(OP_SLTI, 7, 1, 0, -3, 0);
      applyStimulus(OP_SLLI, 8, 2, 0, 3, 0);
      applyStimulus(OP_SLT, 4, 1, 2, 0, 0);
      applyStimulus(OP_SLL, 6, 3, 4, 0, 0);
      waitIdle("enc_idle");
      checkLog("enc_addi", logBase + 0, 0, 32'h00500093);
      checkLog("enc_add", logBase + 1, 0, 32'h002081B3);
      checkLog("enc_lw", logBase + 2, 0, 32'h00812283);
      checkLog("enc_sw", logBase + 3, 0, 32'h00512623);
      checkLog("enc_beq", logBase + 4, 0, 32'hFE208CE3);
      checkLog("enc_slti", logBase + 5, 0, 32'hFFD0A393);
      checkLog("enc_slli", logBase + 6, 0, 32'h00311413);
      checkLog("enc_beq_addr", logBase + 4, 1, 32'h00000010);
      checkOutput("enc_count", count, 9);

      $display("[TB] addressing with start alongside the first push");
      logBase  = wrDataLog.size();
      doneBase = doneSeen;
      start    = 1'b1;
      baseAddr = 32'h100;
      applyStimulus(OP_ADDI, 1, 0, 0, 1, 0);
      applyStimulus(OP_ADDI, 2, 0, 0, 2, 0);
      applyStimulus(OP_ADDI, 3, 0, 0, 3, 1);
      waitIdle("addr_idle");
      checkLog("addr_0", logBase + 0, 1, 32'h100);
      checkLog("addr_1", logBase + 1, 1, 32'h104);
      checkLog("addr_2", logBase + 2, 1, 32'h108);
      checkOutput("addr_done_once", 32'(doneSeen - doneBase), 1);
      checkOutput("addr_count", count, 3);

      $display("[TB] backpressure from imem and a full FIFO");
      doStart(32'h400);
      logBase = wrDataLog.size();
      ackEn   = 0;
      for (int i = 1; i <= 5; i++) applyStimulus(OP_ADDI, i, 0, 0, i * 10, 0);
      @(negedge clk);
      checkOutput("full_ready", bus.req_ready, 0);
      checkOutput("full_we", bus.imem_we, 1);
      @(posedge clk);
      #1;
      ackHold = 5;
      ackEn   = 1;
      applyStimulus(OP_SW, 0, 1, 6, -4, 1);
      waitIdle("bp_idle");
      checkOutput("bp_count", count, 6);
      checkLog("bp_addr_last", logBase + 5, 1, 32'h414);

      $display("[TB] illegal op is dropped");
      doStart(32'h200);
      logBase = wrDataLog.size();
      errBase = errSeen;
      applyStimulus(OP_BAD, 1, 1, 1, 0, 0);
      applyStimulus(OP_ADDI, 2, 0, 0, 7, 1);
      waitIdle("ill_idle");
      checkOutput("ill_err_once", 32'(errSeen - errBase), 1);
      checkOutput("ill_writes", 32'(wrDataLog.size() - logBase), 1);
      checkLog("ill_addr", logBase, 1, 32'h200);
      checkLog("ill_data", logBase, 0, 32'h00700113);

      $display("[TB] out-of-range immediate");
      doStart(32'h300);
      logBase = wrDataLog.size();
      errBase = errSeen;
      applyStimulus(OP_ADDI, 1, 0, 0, 4096, 1);
      waitIdle("imm_idle");
`ifdef INSTR_ENC_IMM_CHECK_EN
      checkOutput("imm_err", 32'(errSeen - errBase), 1);
      checkOutput("imm_writes", 32'(wrDataLog.size() - logBase), 0);
`else
      checkOutput("imm_err", 32'(errSeen - errBase), 0);
      checkLog("imm_addr", logBase, 1, 32'h300);
      checkLog("imm_data", logBase, 0, 32'h00000093);
`endif

      $display("[TB] reset in the middle of a write");
      ackEn   = 0;
      logBase = wrDataLog.size();
      applyStimulus(OP_ADDI, 9, 0, 0, 9, 0);
      seenWe = 0;
      for (int i = 0; i < 20 && !seenWe; i++) begin
         @(negedge clk);
         if (bus.imem_we) seenWe = 1;
      end
      if (!seenWe) failNote("rst_wait_we");
      @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst   = 1'b0;
      ackEn = 1;
      repeat (6) @(negedge clk);
      checkOutput("post_rst_we", bus.imem_we, 0);
      checkOutput("post_rst_count", count, 0);
      checkOutput("post_rst_writes", 32'(wrDataLog.size() - logBase), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
